// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: sequences fetch, decode, execute, memory
// and write-back states and drives the datapath control word.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        ovfl,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic [21:0] ctrl_out,
  output logic        pc_en,
  output logic        instr_done,
  output logic        illegal,
  output logic        ovfl_exc,
  output logic [3:0]  state_dbg
);

  // state    | meaning
  // FETCH    | read instruction, PC <= PC+4 when memory completes
  // DECODE   | dispatch on opcode, precompute branch target into Z
  // MEM_ADDR | effective address for lw/sw
  // MEM_RD   | data read, wait for mem_ready
  // MEM_WB   | load data to register file
  // MEM_WR   | data write, wait for mem_ready
  // R_EXEC   | R-type ALU operation
  // R_WB     | R-type result to rd
  // BRANCH   | beq compare, conditional PC load from Z
  // JUMP     | PC <= jump target
  // I_EXEC   | addi ALU operation
  // I_WB     | addi result to rt
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam int B_FNTYPE   = 0;
  localparam int B_ADDSUB   = 2;
  localparam int B_SRCY     = 4;
  localparam int B_SRCX     = 6;
  localparam int B_LOGICFN  = 8;
  localparam int B_PCWRITE  = 10;
  localparam int B_PCWCOND  = 11;
  localparam int B_PCSRC    = 12;
  localparam int B_IRWRITE  = 14;
  localparam int B_MEMREAD  = 15;
  localparam int B_MEMWRITE = 16;
  localparam int B_IORD     = 17;
  localparam int B_REGWRITE = 18;
  localparam int B_REGDST   = 19;
  localparam int B_MEMTOREG = 20;
  localparam int B_ZWRITE   = 21;

  localparam logic [1:0] TYPE_ARITH = 2'b00;
  localparam logic [1:0] TYPE_LOGIC = 2'b01;
  localparam logic [1:0] TYPE_SHIFT = 2'b10;
  localparam logic [1:0] TYPE_SLT   = 2'b11;

  localparam logic [1:0] SRCY_FOUR  = 2'b00;
  localparam logic [1:0] SRCY_REG   = 2'b01;
  localparam logic [1:0] SRCY_IMM   = 2'b10;
  localparam logic [1:0] SRCY_IMMSH = 2'b11;
  localparam logic [1:0] SRCX_REG   = 2'b00;
  localparam logic [1:0] SRCX_PC    = 2'b01;

  localparam logic [1:0] LOGIC_AND = 2'b00;
  localparam logic [1:0] LOGIC_OR  = 2'b01;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_Z    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  state_t      state;
  logic        running;
  logic        ovfl_flag;
  logic [21:0] ctrl;

  // running is low during reset and for the first edge after release, so the
  // FETCH word appears only once the block is actually sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      running   <= 1'b0;
      ovfl_flag <= 1'b0;
    end else if (!running) begin
      running   <= 1'b1;
      state     <= FETCH;
      ovfl_flag <= 1'b0;
    end else begin
      ovfl_flag <= 1'b0;
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_RTYPE:     state <= R_EXEC;
            OP_LW, OP_SW: state <= MEM_ADDR;
            OP_BEQ:       state <= BRANCH;
            OP_J:         state <= JUMP;
            OP_ADDI:      state <= I_EXEC;
            default:      state <= FETCH;
          endcase
        end
        MEM_ADDR: state <= (opcode == OP_SW) ? MEM_WR : MEM_RD;
        MEM_RD:   if (mem_ready) state <= MEM_WB;
        MEM_WR:   if (mem_ready) state <= FETCH;
        R_EXEC: begin
          case (funct)
            FN_ADD, FN_SUB: begin
              state     <= R_WB;
              ovfl_flag <= ovfl;
            end
            FN_AND, FN_OR, FN_SLT, FN_SLL: state <= R_WB;
            default: state <= FETCH;
          endcase
        end
        I_EXEC: begin
          state     <= I_WB;
          ovfl_flag <= ovfl;
        end
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl       = '0;
    mem_req    = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    ovfl_exc   = 1'b0;
    if (running) begin
      case (state)
        FETCH: begin
          mem_req                  = 1'b1;
          ctrl[B_MEMREAD]          = 1'b1;
          ctrl[B_SRCX +: 2]        = SRCX_PC;
          ctrl[B_SRCY +: 2]        = SRCY_FOUR;
          ctrl[B_FNTYPE +: 2]      = TYPE_ARITH;
          ctrl[B_PCSRC +: 2]       = PCSRC_ALU;
          ctrl[B_IRWRITE]          = mem_ready;
          ctrl[B_PCWRITE]          = mem_ready;
        end
        DECODE: begin
          ctrl[B_SRCX +: 2] = SRCX_PC;
          ctrl[B_SRCY +: 2] = SRCY_IMMSH;
          ctrl[B_ZWRITE]    = 1'b1;
          case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal = 1'b0;
            default: illegal = 1'b1;
          endcase
        end
        MEM_ADDR, I_EXEC: begin
          ctrl[B_SRCX +: 2]   = SRCX_REG;
          ctrl[B_SRCY +: 2]   = SRCY_IMM;
          ctrl[B_FNTYPE +: 2] = TYPE_ARITH;
          ctrl[B_ZWRITE]      = 1'b1;
        end
        MEM_RD: begin
          mem_req          = 1'b1;
          ctrl[B_IORD]     = 1'b1;
          ctrl[B_MEMREAD]  = 1'b1;
        end
        MEM_WR: begin
          mem_req          = 1'b1;
          ctrl[B_IORD]     = 1'b1;
          ctrl[B_MEMWRITE] = 1'b1;
          instr_done       = mem_ready;
        end
        MEM_WB: begin
          ctrl[B_REGWRITE] = 1'b1;
          ctrl[B_MEMTOREG] = 1'b1;
          instr_done       = 1'b1;
        end
        R_EXEC: begin
          ctrl[B_SRCX +: 2] = SRCX_REG;
          ctrl[B_SRCY +: 2] = SRCY_REG;
          ctrl[B_ZWRITE]    = 1'b1;
          case (funct)
            FN_ADD: ctrl[B_FNTYPE +: 2] = TYPE_ARITH;
            FN_SUB: begin
              ctrl[B_FNTYPE +: 2] = TYPE_ARITH;
              ctrl[B_ADDSUB]      = 1'b1;
            end
            FN_AND: begin
              ctrl[B_FNTYPE +: 2]  = TYPE_LOGIC;
              ctrl[B_LOGICFN +: 2] = LOGIC_AND;
            end
            FN_OR: begin
              ctrl[B_FNTYPE +: 2]  = TYPE_LOGIC;
              ctrl[B_LOGICFN +: 2] = LOGIC_OR;
            end
            FN_SLT: begin
              ctrl[B_FNTYPE +: 2] = TYPE_SLT;
              ctrl[B_ADDSUB]      = 1'b1;
            end
            FN_SLL: ctrl[B_FNTYPE +: 2] = TYPE_SHIFT;
            default: illegal = 1'b1;
          endcase
        end
        // an overflowed result is discarded and reported instead of written
        R_WB: begin
          ctrl[B_REGWRITE] = ~ovfl_flag;
          ctrl[B_REGDST]   = 1'b1;
          instr_done       = 1'b1;
          ovfl_exc         = ovfl_flag;
        end
        I_WB: begin
          ctrl[B_REGWRITE] = ~ovfl_flag;
          instr_done       = 1'b1;
          ovfl_exc         = ovfl_flag;
        end
        BRANCH: begin
          ctrl[B_SRCX +: 2]  = SRCX_REG;
          ctrl[B_SRCY +: 2]  = SRCY_REG;
          ctrl[B_ADDSUB]     = 1'b1;
          ctrl[B_PCWCOND]    = 1'b1;
          ctrl[B_PCSRC +: 2] = PCSRC_Z;
          instr_done         = 1'b1;
        end
        JUMP: begin
          ctrl[B_PCWRITE]    = 1'b1;
          ctrl[B_PCSRC +: 2] = PCSRC_JUMP;
          instr_done         = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign ctrl_out  = ctrl;
  assign pc_en     = ctrl[B_PCWRITE] | (ctrl[B_PCWCOND] & alu_zero);
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected outputs are
// queued as each cycle is driven and compared when the cycle is sampled.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        alu_zero;
  logic        ovfl;
  logic        mem_ready;
  logic        mem_req;
  logic [21:0] ctrl_out;
  logic        pc_en;
  logic        instr_done;
  logic        illegal;
  logic        ovfl_exc;
  logic [3:0]  state_dbg;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .alu_zero   (alu_zero),
    .ovfl       (ovfl),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .ctrl_out   (ctrl_out),
    .pc_en      (pc_en),
    .instr_done (instr_done),
    .illegal    (illegal),
    .ovfl_exc   (ovfl_exc),
    .state_dbg  (state_dbg)
  );

  // expected control words assembled from the field map
  localparam logic [21:0] W_ZERO     = 22'h000000;
  localparam logic [21:0] W_FETCH    = 22'h008040;
  localparam logic [21:0] W_FETCH_RD = 22'h00C440;
  localparam logic [21:0] W_DEC      = 22'h200070;
  localparam logic [21:0] W_JUMP     = 22'h002400;
  localparam logic [21:0] W_MADDR    = 22'h200020;
  localparam logic [21:0] W_MRD      = 22'h028000;
  localparam logic [21:0] W_MWR      = 22'h030000;
  localparam logic [21:0] W_MWB      = 22'h140000;
  localparam logic [21:0] W_R_ADD    = 22'h200010;
  localparam logic [21:0] W_R_SUB    = 22'h200014;
  localparam logic [21:0] W_R_AND    = 22'h200011;
  localparam logic [21:0] W_R_OR     = 22'h200111;
  localparam logic [21:0] W_R_SLT    = 22'h200017;
  localparam logic [21:0] W_R_SLL    = 22'h200012;
  localparam logic [21:0] W_RWB      = 22'h0C0000;
  localparam logic [21:0] W_RWB_OV   = 22'h080000;
  localparam logic [21:0] W_BR       = 22'h001814;
  localparam logic [21:0] W_IEX      = 22'h200020;
  localparam logic [21:0] W_IWB      = 22'h040000;

  typedef struct packed {
    logic [3:0]  st;
    logic [21:0] cw;
    logic        chk_cw;
    logic        req;
    logic        pce;
    logic        done;
    logic        ill;
    logic        oexc;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  int    done_seen = 0;
  int    done_exp = 0;
  string scen = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) if (instr_done === 1'b1) done_seen++;

  task automatic cyc(input logic mr, input logic [3:0] st, input logic [21:0] cw,
                     input logic ck, input logic req, input logic pce,
                     input logic done, input logic ill, input logic oexc);
    exp_t e;
    mem_ready = mr;
    e.st = st; e.cw = cw; e.chk_cw = ck; e.req = req;
    e.pce = pce; e.done = done; e.ill = ill; e.oexc = oexc;
    sb.push_back(e);
    if (done) done_exp++;
    @(negedge clk);
    e = sb.pop_front();
    chk({scen, ".state"}, 32'(state_dbg), 32'(e.st));
    if (e.chk_cw) chk({scen, ".ctrl"}, 32'(ctrl_out), 32'(e.cw));
    chk({scen, ".mem_req"}, 32'(mem_req), 32'(e.req));
    chk({scen, ".pc_en"}, 32'(pc_en), 32'(e.pce));
    chk({scen, ".done"}, 32'(instr_done), 32'(e.done));
    chk({scen, ".illegal"}, 32'(illegal), 32'(e.ill));
    chk({scen, ".ovfl_exc"}, 32'(ovfl_exc), 32'(e.oexc));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch();
    cyc(1'b1, 4'd0, W_FETCH_RD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // mem_ready is held high here; the FSM must ignore it outside memory states
  task automatic decode(input logic ill);
    cyc(1'b1, 4'd1, W_DEC, 1'b1, 1'b0, 1'b0, 1'b0, ill, 1'b0);
  endtask

  task automatic run_j();
    scen = "jump"; opcode = 6'b000010; funct = 6'h00;
    fetch(); decode(1'b0);
    cyc(1'b1, 4'd9, W_JUMP, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_r(input string nm, input logic [5:0] fn, input logic ov,
                       input logic [21:0] exw, input logic oexp, input logic bad);
    scen = nm; opcode = 6'b000000; funct = fn; ovfl = ov;
    fetch(); decode(1'b0);
    if (bad) begin
      cyc(1'b1, 4'd6, exw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end else begin
      cyc(1'b1, 4'd6, exw, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      ovfl = 1'b0;
      cyc(1'b1, 4'd7, oexp ? W_RWB_OV : W_RWB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, oexp);
    end
    ovfl = 1'b0;
  endtask

  task automatic run_addi(input string nm, input logic ov);
    scen = nm; opcode = 6'b001000; ovfl = ov;
    fetch(); decode(1'b0);
    cyc(1'b1, 4'd10, W_IEX, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ovfl = 1'b0;
    cyc(1'b1, 4'd11, ov ? W_ZERO : W_IWB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ov);
  endtask

  task automatic run_beq(input string nm, input logic az);
    scen = nm; opcode = 6'b000100; alu_zero = az;
    fetch(); decode(1'b0);
    cyc(1'b1, 4'd8, W_BR, 1'b1, 1'b0, az, 1'b1, 1'b0, 1'b0);
    alu_zero = 1'b1;
  endtask

  task automatic idle_after_reset();
    reset = 1'b0;
    cyc(1'b1, 4'd0, W_ZERO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h00;
    alu_zero = 1'b1; ovfl = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    scen = "reset";
    cyc(1'b1, 4'd0, W_ZERO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    scen = "release";
    idle_after_reset();

    run_j();
    run_r("r_add", 6'b100000, 1'b0, W_R_ADD, 1'b0, 1'b0);
    run_r("r_sub_ovfl", 6'b100010, 1'b1, W_R_SUB, 1'b1, 1'b0);
    run_r("r_and", 6'b100100, 1'b0, W_R_AND, 1'b0, 1'b0);
    run_r("r_or_ovfl", 6'b100101, 1'b1, W_R_OR, 1'b0, 1'b0);
    run_r("r_slt_ovfl", 6'b101010, 1'b1, W_R_SLT, 1'b0, 1'b0);
    run_r("r_sll", 6'b000000, 1'b0, W_R_SLL, 1'b0, 1'b0);
    run_r("r_badfn", 6'b111111, 1'b0, W_R_ADD, 1'b0, 1'b1);

    scen = "lw"; opcode = 6'b100011;
    cyc(1'b0, 4'd0, W_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(); decode(1'b0);
    cyc(1'b1, 4'd2, W_MADDR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd3, W_MRD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd3, W_MRD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd3, W_MRD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd4, W_MWB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    scen = "sw"; opcode = 6'b101011;
    fetch(); decode(1'b0);
    cyc(1'b1, 4'd2, W_MADDR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd5, W_MWR, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    run_beq("beq_taken", 1'b1);
    run_beq("beq_not", 1'b0);

    scen = "bad_op"; opcode = 6'b111111;
    fetch(); decode(1'b1);

    run_addi("addi_ovfl", 1'b1);
    run_addi("addi", 1'b0);

    scen = "sw_reset"; opcode = 6'b101011;
    fetch(); decode(1'b0);
    cyc(1'b1, 4'd2, W_MADDR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd5, W_MWR, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("sw_reset.async_state", 32'(state_dbg), 32'd0);
    chk("sw_reset.async_memwrite", 32'(ctrl_out[16]), 32'd0);
    cyc(1'b1, 4'd0, W_ZERO, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_after_reset();
    run_j();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(done_seen), 32'(done_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- alu_zero  in  1  ALU zero flag.
- ovfl  in  1  ALU overflow flag.
- mem_ready  in  1  memory completion strobe.
- mem_req  out  1  memory request.
- ctrl_out  out  22  ALU/datapath control word.
- pc_en  out  1  PC load enable.
- instr_done  out  1  one-cycle pulse on the final cycle of an instruction.
- illegal  out  1  one-cycle pulse when an opcode or funct is unknown.
- ovfl_exc  out  1  one-cycle pulse when an arithmetic instruction overflows.
- state_dbg  out  4  current state encoding.

REQ-002 The ctrl_out fields SHALL be:
- [1:0] FNTYPE: 00 arith, 01 logic, 10 shift, 11 slt.
- [2] ADDSUB: 1 = subtract.
- [3] SHIFTDIR: 0 = left.
- [5:4] ALUSRCY: 00 constant 4, 01 Y register, 10 imm, 11 imm<<2.
- [7:6] ALUSRCX: 00 X register, 01 PC.
- [9:8] LOGICFN: 00 and, 01 or, 10 xor, 11 nor.
- [10] PCWRITE.
- [11] PCWRITECOND.
- [13:12] PCSRC: 00 ALU result, 01 Z register, 10 jump target.
- [14] IRWRITE.
- [15] MEMREAD.
- [16] MEMWRITE.
- [17] IORD.
- [18] REGWRITE.
- [19] REGDST.
- [20] MEMTOREG.
- [21] ZWRITE.

Function
REQ-003 The block SHALL be a Moore FSM with these states (state_dbg encoding): FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11. All unlisted control bits are 0 in every state.
REQ-004 FETCH SHALL drive:
- mem_req=1, MEMREAD=1, IORD=0.
- ALUSRCX=01, ALUSRCY=00, FNTYPE=00, ADDSUB=0, PCSRC=00.
- IRWRITE=1 and PCWRITE=1 only in the cycle where mem_ready=1.
- Transition: stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-005 DECODE SHALL drive ALUSRCX=01, ALUSRCY=11, ZWRITE=1 (precomputes the branch target). It SHALL dispatch on opcode:
- 000000 -> R_EXEC.
- 100011 (lw) or 101011 (sw) -> MEM_ADDR.
- 000100 (beq) -> BRANCH.
- 000010 (j) -> JUMP.
- 001000 (addi) -> I_EXEC.
- Any other opcode -> pulse illegal and go to FETCH.
REQ-006 MEM_ADDR SHALL drive ALUSRCX=00, ALUSRCY=10, arith add, ZWRITE=1; next state is MEM_RD for lw, MEM_WR for sw.
REQ-007 MEM_RD and MEM_WR SHALL drive:
- mem_req=1, IORD=1, plus MEMREAD (MEM_RD) or MEMWRITE (MEM_WR).
- Hold the state while mem_ready=0.
- On mem_ready=1: MEM_RD goes to MEM_WB; MEM_WR pulses instr_done and goes to FETCH.
REQ-008 MEM_WB SHALL drive REGWRITE=1, MEMTOREG=1, REGDST=0, pulse instr_done, and go to FETCH.
REQ-009 R_EXEC SHALL drive ALUSRCX=00, ALUSRCY=01, ZWRITE=1, decoding funct as:
- 100000 add.
- 100010 sub (ADDSUB=1).
- 100100 and.
- 100101 or.
- 101010 slt (FNTYPE=11, ADDSUB=1).
- 000000 sll (FNTYPE=10, SHIFTDIR=0).
- Any other funct: pulse illegal and go to FETCH. Otherwise go to R_WB.
REQ-010 R_WB SHALL drive REGWRITE=1, REGDST=1, MEMTOREG=0, pulse instr_done, and go to FETCH.
REQ-011 I_EXEC SHALL drive ALUSRCX=00, ALUSRCY=10, arith add, ZWRITE=1, and go to I_WB. I_WB SHALL drive REGWRITE=1, REGDST=0, pulse instr_done, and go to FETCH.
REQ-012 Overflow handling SHALL be:
- If ovfl=1 in the R_EXEC cycle of add/sub, or in the I_EXEC cycle, set a sticky ovfl flag.
- In the following WB state, force REGWRITE=0, pulse ovfl_exc with instr_done, then clear the flag.
- slt, logic and shift ops SHALL ignore ovfl.
REQ-013 BRANCH SHALL drive ALUSRCX=00, ALUSRCY=01, ADDSUB=1, PCWRITECOND=1, PCSRC=01, pulse instr_done, and go to FETCH.
REQ-014 JUMP SHALL drive PCWRITE=1, PCSRC=10, pulse instr_done, and go to FETCH.
REQ-015 pc_en SHALL be combinational: PCWRITE | (PCWRITECOND & alu_zero).
REQ-016 Latency with mem_ready tied to 1 SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles. Each cycle of mem_ready=0 in a memory state SHALL add exactly 1 cycle.
REQ-017 mem_ready=1 outside FETCH, MEM_RD and MEM_WR SHALL be ignored.

Reset
REQ-018 While reset=1:
- state SHALL be FETCH.
- ctrl_out, mem_req, pc_en, instr_done, illegal and ovfl_exc SHALL be 0.
- The ovfl flag SHALL be clear.
REQ-019 On the first rising edge after reset is released, the block SHALL drive the FETCH word.
REQ-020 A reset asserted mid-instruction SHALL abort it immediately (asynchronously) with no write strobes and no instr_done.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset, mem_ready=1, opcode=000010: state_dbg sequence 0,1,9,0; PC+4 fetch word ctrl_out[7:0]=8'h40; pc_en=1 in FETCH and JUMP.
- R-type add (funct=100000), ovfl=0: states 0,1,6,7; REGWRITE=1 and REGDST=1 in R_WB; instr_done on cycle 4.
- lw with mem_ready low for 2 cycles in MEM_RD: states 0,1,2,3,3,3,4; MEMTOREG=1 in MEM_WB; 7 cycles total.
- beq: alu_zero=1 gives pc_en=1 in BRANCH; a repeat with alu_zero=0 gives pc_en=0; 3 cycles each.
- opcode=111111: illegal pulses in DECODE, then FETCH; addi with ovfl=1: ovfl_exc=1 and REGWRITE=0 in I_WB.
- reset asserted in MEM_WR: state_dbg=0 and MEMWRITE=0 within the same cycle; no instr_done.
